axi_slave_ram: RTL and testbench

- AXI4 slave responder terminating one slave port of the AXI slave switch; the far end of the bus the switch drives.
- Backs a word-addressed dual-port RAM, 32-bit data, byte strobes.
- Supports FIXED/INCR/WRAP bursts up to 256 beats.
- Write and read channels run fully independently.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 30 +++
 rtl/axi_slave_ram.sv | 213 +++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the slave RAM responder: burst types, response
// codes and the write/read FSM state constants.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for an AXI burst (FIXED/INCR/WRAP).
// WRAP is only honoured for lengths 2/4/8/16 beats; otherwise it counts up.
module axi_burst_addr_gen (
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    import axi_pkg::*;

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic        wrap_ok;

    assign incr_addr = addr + 32'd4;
    assign wrap_mask = {22'd0, len, 2'b11};
    assign wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

    // Select the next address by burst type; reserved 2'b11 counts up.
    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  if (wrap_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave responder backed by a word-addressed 32-bit RAM with byte
// strobes. Write and read channels run independently.
// Optional macro AXI_SLAVE_RAM_ERR_RESP_EN: beats outside the RAM return
// SLVERR (writes suppressed, reads return zero); otherwise the RAM aliases.
module axi_slave_ram #(
    parameter int S_ID           = 4,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [S_ID-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]     SLAVE_WR_ADDR,
    input  logic [7:0]      SLAVE_WR_ADDR_LEN,
    input  logic [1:0]      SLAVE_WR_ADDR_BURST,
    input  logic            SLAVE_WR_ADDR_VALID,
    output logic            SLAVE_WR_ADDR_READY,
    input  logic [31:0]     SLAVE_WR_DATA,
    input  logic [3:0]      SLAVE_WR_STRB,
    input  logic            SLAVE_WR_DATA_LAST,
    input  logic            SLAVE_WR_DATA_VALID,
    output logic            SLAVE_WR_DATA_READY,
    output logic [S_ID-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]      SLAVE_WR_BACK_RESP,
    output logic            SLAVE_WR_BACK_VALID,
    input  logic            SLAVE_WR_BACK_READY,
    input  logic [S_ID-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]     SLAVE_RD_ADDR,
    input  logic [7:0]      SLAVE_RD_ADDR_LEN,
    input  logic [1:0]      SLAVE_RD_ADDR_BURST,
    input  logic            SLAVE_RD_ADDR_VALID,
    output logic            SLAVE_RD_ADDR_READY,
    output logic [S_ID-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]     SLAVE_RD_DATA,
    output logic [1:0]      SLAVE_RD_DATA_RESP,
    output logic            SLAVE_RD_DATA_LAST,
    output logic            SLAVE_RD_DATA_VALID,
    input  logic            SLAVE_RD_DATA_READY
);
    import axi_pkg::*;

    localparam int unsigned MEM_DEPTH = 2 ** MEM_DEPTH_LOG2;

    logic [31:0] mem [0:MEM_DEPTH-1];

    // Write channel state
    logic [1:0]      wstate;
    logic [S_ID-1:0] wid;
    logic [31:0]     waddr;
    logic [7:0]      wlen;
    logic [1:0]      wburst;
    logic [7:0]      wcnt;
    logic            werr;
    logic [31:0]     w_next;
    logic            w_oor;
    logic            aw_hs;
    logic            w_hs;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;

    // Read channel state
    logic [0:0]      rstate;
    logic [S_ID-1:0] rid;
    logic [31:0]     raddr;
    logic [7:0]      rlen;
    logic [1:0]      rburst;
    logic [7:0]      rcnt;
    logic [31:0]     rdata;
    logic            rerr;
    logic [31:0]     rd_addr_sel;
    logic [7:0]      rd_len_sel;
    logic [1:0]      rd_burst_sel;
    logic [31:0]     r_next;
    logic            r_oor;
    logic [31:0]     rd_word;
    logic            ar_hs;
    logic            r_hs;
    logic            r_last;

    // Bursts terminate by beat count, so WLAST is intentionally not consulted.
    logic unused_wlast;
    assign unused_wlast = SLAVE_WR_DATA_LAST;

    assign aw_hs = (wstate == W_IDLE) && SLAVE_WR_ADDR_VALID;
    assign w_hs  = (wstate == W_DATA) && SLAVE_WR_DATA_VALID;
    assign w_idx = waddr[MEM_DEPTH_LOG2+1:2];

    // In IDLE the read address path looks at the incoming AR so beat 0 can be
    // fetched on the handshake edge; afterwards it follows the burst pointer.
    assign rd_addr_sel  = (rstate == R_IDLE) ? SLAVE_RD_ADDR       : raddr;
    assign rd_len_sel   = (rstate == R_IDLE) ? SLAVE_RD_ADDR_LEN   : rlen;
    assign rd_burst_sel = (rstate == R_IDLE) ? SLAVE_RD_ADDR_BURST : rburst;

    assign ar_hs  = (rstate == R_IDLE) && SLAVE_RD_ADDR_VALID;
    assign r_last = (rstate == R_DATA) && (rcnt == rlen);
    assign r_hs   = (rstate == R_DATA) && SLAVE_RD_DATA_READY;

`ifdef AXI_SLAVE_RAM_ERR_RESP_EN
    assign w_oor = |waddr[31:MEM_DEPTH_LOG2+2];
    assign r_oor = |rd_addr_sel[31:MEM_DEPTH_LOG2+2];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign rd_word = r_oor ? '0 : mem[rd_addr_sel[MEM_DEPTH_LOG2+1:2]];

    axi_burst_addr_gen u_wr_addr_gen (
        .addr      (waddr),
        .len       (wlen),
        .burst     (wburst),
        .next_addr (w_next)
    );

    axi_burst_addr_gen u_rd_addr_gen (
        .addr      (rd_addr_sel),
        .len       (rd_len_sel),
        .burst     (rd_burst_sel),
        .next_addr (r_next)
    );

    // Byte-lane RAM write; the registered read below sees the old word (read-first).
    always_ff @(posedge clk) begin
        if (w_hs && !w_oor) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b]) mem[w_idx][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

    // Write FSM: accept AW, count W beats, then hold B until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            wid    <= '0;
            waddr  <= '0;
            wlen   <= '0;
            wburst <= '0;
            wcnt   <= '0;
            werr   <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (aw_hs) begin
                    wid    <= SLAVE_WR_ADDR_ID;
                    waddr  <= SLAVE_WR_ADDR;
                    wlen   <= SLAVE_WR_ADDR_LEN;
                    wburst <= SLAVE_WR_ADDR_BURST;
                    wcnt   <= '0;
                    werr   <= 1'b0;
                    wstate <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    waddr <= w_next;
                    wcnt  <= wcnt + 8'd1;
                    if (w_oor) werr <= 1'b1;
                    if (wcnt == wlen) wstate <= W_RESP;
                end
                W_RESP: if (SLAVE_WR_BACK_READY) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: prefetch one beat ahead so R streams at one beat per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rid    <= '0;
            raddr  <= '0;
            rlen   <= '0;
            rburst <= '0;
            rcnt   <= '0;
            rdata  <= '0;
            rerr   <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rid    <= SLAVE_RD_ADDR_ID;
                    rlen   <= SLAVE_RD_ADDR_LEN;
                    rburst <= SLAVE_RD_ADDR_BURST;
                    rcnt   <= '0;
                    raddr  <= r_next;
                    rdata  <= rd_word;
                    rerr   <= r_oor;
                    rstate <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last) begin
                        rstate <= R_IDLE;
                    end else begin
                        rcnt  <= rcnt + 8'd1;
                        raddr <= r_next;
                        rdata <= rd_word;
                        rerr  <= r_oor;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign SLAVE_WR_ADDR_READY = (wstate == W_IDLE);
    assign SLAVE_WR_DATA_READY = (wstate == W_DATA);
    assign SLAVE_WR_BACK_VALID = (wstate == W_RESP);
    assign SLAVE_WR_BACK_ID    = wid;
    assign SLAVE_WR_BACK_RESP  = werr ? RESP_SLVERR : RESP_OKAY;

    assign SLAVE_RD_ADDR_READY = (rstate == R_IDLE);
    assign SLAVE_RD_DATA_VALID = (rstate == R_DATA);
    assign SLAVE_RD_DATA_LAST  = r_last;
    assign SLAVE_RD_BACK_ID    = rid;
    assign SLAVE_RD_DATA       = rdata;
    assign SLAVE_RD_DATA_RESP  = rerr ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed testbench for axi_slave_ram.
module tb_axi_slave_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_slave_ram #(.S_ID(4), .MEM_DEPTH_LOG2(10)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .SLAVE_WR_ADDR_ID    (aw_id),
        .SLAVE_WR_ADDR       (aw_addr),
        .SLAVE_WR_ADDR_LEN   (aw_len),
        .SLAVE_WR_ADDR_BURST (aw_burst),
        .SLAVE_WR_ADDR_VALID (aw_valid),
        .SLAVE_WR_ADDR_READY (aw_ready),
        .SLAVE_WR_DATA       (w_data),
        .SLAVE_WR_STRB       (w_strb),
        .SLAVE_WR_DATA_LAST  (w_last),
        .SLAVE_WR_DATA_VALID (w_valid),
        .SLAVE_WR_DATA_READY (w_ready),
        .SLAVE_WR_BACK_ID    (b_id),
        .SLAVE_WR_BACK_RESP  (b_resp),
        .SLAVE_WR_BACK_VALID (b_valid),
        .SLAVE_WR_BACK_READY (b_ready),
        .SLAVE_RD_ADDR_ID    (ar_id),
        .SLAVE_RD_ADDR       (ar_addr),
        .SLAVE_RD_ADDR_LEN   (ar_len),
        .SLAVE_RD_ADDR_BURST (ar_burst),
        .SLAVE_RD_ADDR_VALID (ar_valid),
        .SLAVE_RD_ADDR_READY (ar_ready),
        .SLAVE_RD_BACK_ID    (r_id),
        .SLAVE_RD_DATA       (r_data),
        .SLAVE_RD_DATA_RESP  (r_resp),
        .SLAVE_RD_DATA_LAST  (r_last),
        .SLAVE_RD_DATA_VALID (r_valid),
        .SLAVE_RD_DATA_READY (r_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
        while (aw_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check("aw_ready", 32'(aw_ready), 32'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        while (w_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check("w_ready", 32'(w_ready), 32'd1);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic b_wait(input logic [3:0] exp_id, input logic [1:0] exp_resp, input string tag);
        int n = 0;
        b_ready = 1'b1;
        while (b_valid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check({tag, "_bvalid"}, 32'(b_valid), 32'd1);
        check({tag, "_bid"}, 32'(b_id), 32'(exp_id));
        check({tag, "_bresp"}, 32'(b_resp), 32'(exp_resp));
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
        while (ar_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check("ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] exp_id, input logic [31:0] exp_data,
                          input logic exp_last, input logic [1:0] exp_resp, input string tag);
        int n = 0;
        r_ready = 1'b1;
        while (r_valid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        check({tag, "_rvalid"}, 32'(r_valid), 32'd1);
        check({tag, "_rdata"}, r_data, exp_data);
        check({tag, "_rlast"}, 32'(r_last), 32'(exp_last));
        check({tag, "_rid"}, 32'(r_id), 32'(exp_id));
        check({tag, "_rresp"}, 32'(r_resp), 32'(exp_resp));
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [31:0] d0, input logic [31:0] step,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
        aw_send(id, addr, 8'(len), burst);
        for (int i = 0; i <= len; i++) w_send(d0 + step * 32'(i), strb, i == len);
        b_wait(id, exp_resp, tag);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [31:0] d0, input logic [31:0] step,
                            input logic [1:0] exp_resp, input string tag);
        ar_send(id, addr, 8'(len), burst);
        for (int i = 0; i <= len; i++) r_beat(id, d0 + step * 32'(i), i == len, exp_resp, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0;
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_awready", 32'(aw_ready), 32'd1);
        check("rst_arready", 32'(ar_ready), 32'd1);
        check("rst_wready", 32'(w_ready), 32'd0);
        check("rst_bvalid", 32'(b_valid), 32'd0);
        check("rst_rvalid", 32'(r_valid), 32'd0);
        check("rst_rlast", 32'(r_last), 32'd0);
        check("rst_bid", 32'(b_id), 32'd0);
        check("rst_bresp", 32'(b_resp), 32'd0);
        check("rst_rid", 32'(r_id), 32'd0);
        check("rst_rdata", r_data, 32'd0);
        check("rst_rresp", 32'(r_resp), 32'd0);

        // 1: INCR write 1..4 at 0x10, read back
        wr_burst(4'h3, 32'h10, 3, 2'b01, 32'd1, 32'd1, 4'hF, 2'b00, "t1_w");
        rd_burst(4'h5, 32'h10, 3, 2'b01, 32'd1, 32'd1, 2'b00, "t1_r");

        // 2: WRAP len=3 at 0x38 over words holding their own address
        wr_burst(4'h1, 32'h30, 3, 2'b01, 32'h30, 32'd4, 4'hF, 2'b00, "t2_wsetup");
        ar_send(4'h4, 32'h38, 8'd3, 2'b10);
        r_beat(4'h4, 32'h38, 1'b0, 2'b00, "t2_wrap0");
        r_beat(4'h4, 32'h3C, 1'b0, 2'b00, "t2_wrap1");
        r_beat(4'h4, 32'h30, 1'b0, 2'b00, "t2_wrap2");
        r_beat(4'h4, 32'h34, 1'b1, 2'b00, "t2_wrap3");
        // FIXED len=2 at 0x20: last beat wins
        wr_burst(4'h2, 32'h20, 2, 2'b00, 32'hA, 32'd1, 4'hF, 2'b00, "t2_fixed_w");
        rd_burst(4'h2, 32'h20, 0, 2'b01, 32'hC, 32'd0, 2'b00, "t2_fixed_r");
        // WRAP len=1 at 0x14 wraps in an 8-byte window: 0x14 then 0x10
        ar_send(4'h8, 32'h14, 8'd1, 2'b10);
        r_beat(4'h8, 32'd2, 1'b0, 2'b00, "t2_wrap2b0");
        r_beat(4'h8, 32'd1, 1'b1, 2'b00, "t2_wrap2b1");
        // WRAP len=2 is not a legal wrap length: behaves as INCR 0x18,0x1C,0x20
        ar_send(4'h9, 32'h18, 8'd2, 2'b10);
        r_beat(4'h9, 32'd3, 1'b0, 2'b00, "t2_wrap3b0");
        r_beat(4'h9, 32'd4, 1'b0, 2'b00, "t2_wrap3b1");
        r_beat(4'h9, 32'hC, 1'b1, 2'b00, "t2_wrap3b2");

        // 3: byte strobes
        wr_burst(4'h0, 32'h40, 0, 2'b01, 32'h11223344, 32'd0, 4'hF, 2'b00, "t3_w0");
        wr_burst(4'h0, 32'h40, 0, 2'b01, 32'hAABBCCDD, 32'd0, 4'b0101, 2'b00, "t3_w1");
        rd_burst(4'h0, 32'h40, 0, 2'b01, 32'h11BB33DD, 32'd0, 2'b00, "t3_r");

        // 4: R READY stalls
        ar_send(4'h2, 32'h10, 8'd3, 2'b01);
        r_beat(4'h2, 32'd1, 1'b0, 2'b00, "t4_b0");
        for (int i = 0; i < 2; i++) begin
            check("t4_stall_data", r_data, 32'd2);
            check("t4_stall_last", 32'(r_last), 32'd0);
            check("t4_stall_valid", 32'(r_valid), 32'd1);
            check("t4_stall_arready", 32'(ar_ready), 32'd0);
            @(posedge clk); #1;
        end
        r_beat(4'h2, 32'd2, 1'b0, 2'b00, "t4_b1");
        r_beat(4'h2, 32'd3, 1'b0, 2'b00, "t4_b2");
        for (int i = 0; i < 2; i++) begin
            check("t4_laststall_data", r_data, 32'd4);
            check("t4_laststall_last", 32'(r_last), 32'd1);
            check("t4_laststall_arready", 32'(ar_ready), 32'd0);
            @(posedge clk); #1;
        end
        r_beat(4'h2, 32'd4, 1'b1, 2'b00, "t4_b3");
        check("t4_done_arready", 32'(ar_ready), 32'd1);
        check("t4_done_rvalid", 32'(r_valid), 32'd0);

        // 5: concurrent 16-beat write and read on disjoint regions
        wr_burst(4'h1, 32'h200, 15, 2'b01, 32'h2000, 32'd1, 4'hF, 2'b00, "t5_setup");
        fork
            wr_burst(4'hA, 32'h300, 15, 2'b01, 32'h3000, 32'd1, 4'hF, 2'b00, "t5_w");
            rd_burst(4'h6, 32'h200, 15, 2'b01, 32'h2000, 32'd1, 2'b00, "t5_r");
        join
        rd_burst(4'h7, 32'h300, 15, 2'b01, 32'h3000, 32'd1, 2'b00, "t5_rb");

        // 6: out-of-range address
        wr_burst(4'h0, 32'h0, 0, 2'b01, 32'h5A5A5A5A, 32'd0, 4'hF, 2'b00, "t6_w0");
`ifdef AXI_SLAVE_RAM_ERR_RESP_EN
        wr_burst(4'h9, 32'h0010_0000, 0, 2'b01, 32'hDEADBEEF, 32'd0, 4'hF, 2'b10, "t6_woor");
        rd_burst(4'h3, 32'h0, 0, 2'b01, 32'h5A5A5A5A, 32'd0, 2'b00, "t6_r0");
        rd_burst(4'h3, 32'h0010_0000, 0, 2'b01, 32'h0, 32'd0, 2'b10, "t6_roor");
`else
        wr_burst(4'h9, 32'h0010_0000, 0, 2'b01, 32'hDEADBEEF, 32'd0, 4'hF, 2'b00, "t6_walias");
        rd_burst(4'h3, 32'h0, 0, 2'b01, 32'hDEADBEEF, 32'd0, 2'b00, "t6_r0");
        rd_burst(4'h3, 32'h0010_0000, 0, 2'b01, 32'hDEADBEEF, 32'd0, 2'b00, "t6_ralias");
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
